// File: rtl/sparrow_dmem_resp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sparrow_dmem_resp: data-memory target with RAM and MMIO (timer,      |
// | console, tohost, error status). Rev 1.0                              |
// +----------------------------------------------------------------------+
module sparrow_dmem_resp #(
  parameter logic [31:0] DMEM_BASE  = 32'h0001_0000,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dmem_req,
  input  logic [31:0] i_dmem_addr,
  input  logic [1:0]  i_dmem_byte_en,
  input  logic        i_dmem_wr_en,
  input  logic [31:0] i_dmem_wr_data,
  output logic [31:0] o_dmem_rd_data,
  output logic        o_cons_valid,
  output logic [7:0]  o_cons_data,
  output logic        o_halt,
  output logic [31:0] o_exit_code,
  output logic [2:0]  o_err
);

  localparam int          c_idx_w    = $clog2(DMEM_DEPTH);
  localparam logic [32:0] c_dmem_end = {1'b0, DMEM_BASE} + 33'(4 * DMEM_DEPTH);
  localparam logic [1:0]  c_sz_byte  = 2'b00;
  localparam logic [1:0]  c_sz_half  = 2'b01;
  localparam logic [1:0]  c_sz_rsvd  = 2'b10;
  localparam logic [1:0]  c_sz_word  = 2'b11;

  localparam logic [2:0]  c_off_mtime_lo = 3'd0;
  localparam logic [2:0]  c_off_mtime_hi = 3'd1;
  localparam logic [2:0]  c_off_tohost   = 3'd2;
  localparam logic [2:0]  c_off_console  = 3'd3;
  localparam logic [2:0]  c_off_err      = 3'd4;

  logic [31:0]        r_mem [DMEM_DEPTH];
  logic [63:0]        r_mtime;
  logic [31:0]        r_hi_shadow;
  logic               r_cons_valid;
  logic [7:0]         r_cons_data;
  logic               r_halt;
  logic [31:0]        r_exit_code;
  logic [2:0]         r_err;

  logic               w_ram_hit;
  logic               w_mmio_hit;
  logic               w_rsvd;
  logic               w_misaligned;
  logic               w_unmapped;
  logic [2:0]         w_new_err;
  logic               w_legal;
  logic               w_ram_acc;
  logic               w_mmio_acc;
  logic [2:0]         w_mmio_off;
  logic [31:0]        w_offs;
  logic [c_idx_w-1:0] w_idx;
  logic [31:0]        w_ram_word;
  logic [31:0]        w_ram_shift;
  logic [31:0]        w_rd_data;
  logic [3:0]         w_lanes;
  logic [31:0]        w_wr_word;
  logic               w_ram_we;
  logic               w_cons_wr;
  logic               w_tohost_wr;
  logic               w_lo_rd;
  logic [2:0]         w_err_clr;

  // Address decode and legality; every illegal access is squashed to a no-op.
  assign w_ram_hit    = ({1'b0, i_dmem_addr} >= {1'b0, DMEM_BASE}) &&
                        ({1'b0, i_dmem_addr} <  c_dmem_end);
  assign w_mmio_hit   = (i_dmem_addr[31:5] == MMIO_BASE[31:5]);
  assign w_rsvd       = (i_dmem_byte_en == c_sz_rsvd);
  assign w_misaligned = ((i_dmem_byte_en == c_sz_half) && i_dmem_addr[0]) ||
                        ((i_dmem_byte_en == c_sz_word) && (i_dmem_addr[1:0] != 2'b00)) ||
                        (w_mmio_hit && ((i_dmem_byte_en == c_sz_byte) ||
                                        (i_dmem_byte_en == c_sz_half)));
  assign w_unmapped   = !w_ram_hit && !w_mmio_hit;
  assign w_new_err    = i_dmem_req ? {w_rsvd, w_unmapped, w_misaligned} : 3'b000;
  assign w_legal      = i_dmem_req && !w_rsvd && !w_misaligned && !w_unmapped;
  assign w_ram_acc    = w_legal && w_ram_hit;
  assign w_mmio_acc   = w_legal && w_mmio_hit;
  assign w_mmio_off   = i_dmem_addr[4:2];

  assign w_offs       = i_dmem_addr - DMEM_BASE;
  assign w_idx        = c_idx_w'(w_offs >> 2);
  assign w_ram_word   = r_mem[w_idx];
  assign w_ram_shift  = w_ram_word >> {i_dmem_addr[1:0], 3'b000};

  always_comb begin
    w_rd_data = 32'h0;
    if (w_ram_acc && !i_dmem_wr_en) begin
      case (i_dmem_byte_en)
        c_sz_byte: w_rd_data = {24'h0, w_ram_shift[7:0]};
        c_sz_half: w_rd_data = {16'h0, w_ram_shift[15:0]};
        default:   w_rd_data = w_ram_word;
      endcase
    end else if (w_mmio_acc && !i_dmem_wr_en) begin
      case (w_mmio_off)
        c_off_mtime_lo: w_rd_data = r_mtime[31:0];
        c_off_mtime_hi: w_rd_data = r_hi_shadow;
        c_off_tohost:   w_rd_data = r_exit_code;
        c_off_err:      w_rd_data = {29'h0, r_err};
        default:        w_rd_data = 32'h0;
      endcase
    end
  end

  // Replicate narrow data across all lanes; the lane mask picks the target.
  always_comb begin
    w_lanes   = 4'b1111;
    w_wr_word = i_dmem_wr_data;
    case (i_dmem_byte_en)
      c_sz_byte: begin
        w_lanes   = 4'b0001 << i_dmem_addr[1:0];
        w_wr_word = {4{i_dmem_wr_data[7:0]}};
      end
      c_sz_half: begin
        w_lanes   = 4'b0011 << {i_dmem_addr[1], 1'b0};
        w_wr_word = {2{i_dmem_wr_data[15:0]}};
      end
      default: begin
        w_lanes   = 4'b1111;
        w_wr_word = i_dmem_wr_data;
      end
    endcase
  end

  assign w_ram_we    = w_ram_acc && i_dmem_wr_en && !i_reset;
  assign w_cons_wr   = w_mmio_acc && i_dmem_wr_en && (w_mmio_off == c_off_console);
  assign w_tohost_wr = w_mmio_acc && i_dmem_wr_en && (w_mmio_off == c_off_tohost);
  assign w_lo_rd     = w_mmio_acc && !i_dmem_wr_en && (w_mmio_off == c_off_mtime_lo);
  assign w_err_clr   = (w_mmio_acc && i_dmem_wr_en && (w_mmio_off == c_off_err)) ?
                       i_dmem_wr_data[2:0] : 3'b000;

  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_lanes[i]) r_mem[w_idx][8*i +: 8] <= w_wr_word[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mtime      <= 64'h0;
      r_hi_shadow  <= 32'h0;
      r_cons_valid <= 1'b0;
      r_cons_data  <= 8'h0;
      r_halt       <= 1'b0;
      r_exit_code  <= 32'h0;
      r_err        <= 3'b000;
    end else begin
      r_mtime      <= r_mtime + 64'd1;
      r_cons_valid <= w_cons_wr;
      if (w_cons_wr) r_cons_data <= i_dmem_wr_data[7:0];
      if (w_lo_rd)   r_hi_shadow <= r_mtime[63:32];
      if (w_tohost_wr && !r_halt) begin
        r_halt      <= 1'b1;
        r_exit_code <= i_dmem_wr_data;
      end
      // New errors are ORed after the clear so they survive a same-cycle clear.
      r_err <= (r_err & ~w_err_clr) | w_new_err;
    end
  end

  assign o_dmem_rd_data = w_rd_data;
  assign o_cons_valid   = r_cons_valid;
  assign o_cons_data    = r_cons_data;
  assign o_halt         = r_halt;
  assign o_exit_code    = r_exit_code;
  assign o_err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sparrow_dmem_resp.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for sparrow_dmem_resp: driver pushes expected outputs per
// cycle from a byte-level memory model; monitor compares on the falling edge.
module tb_sparrow_dmem_resp;

  localparam logic [31:0] DMEM_BASE  = 32'h0001_0000;
  localparam int          DMEM_DEPTH = 1024;
  localparam logic [31:0] MMIO_BASE  = 32'hFFFF_0000;
  localparam longint      RAM_END    = longint'(DMEM_BASE) + 4 * DMEM_DEPTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [31:0] addr;
  logic [1:0]  sz;
  logic        wr;
  logic [31:0] wdata;
  logic [31:0] rd_data;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        halt;
  logic [31:0] exit_code;
  logic [2:0]  err;

  sparrow_dmem_resp #(
    .DMEM_BASE (DMEM_BASE),
    .DMEM_DEPTH(DMEM_DEPTH),
    .MMIO_BASE (MMIO_BASE)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_dmem_req    (req),
    .i_dmem_addr   (addr),
    .i_dmem_byte_en(sz),
    .i_dmem_wr_en  (wr),
    .i_dmem_wr_data(wdata),
    .o_dmem_rd_data(rd_data),
    .o_cons_valid  (cons_valid),
    .o_cons_data   (cons_data),
    .o_halt        (halt),
    .o_exit_code   (exit_code),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          chk_rd;
    logic [31:0] rd;
    logic [31:0] mask;
    bit          chk_state;
    logic [2:0]  err;
    bit          halt;
    logic [31:0] exit_code;
    bit          cv;
    logic [7:0]  cd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  bit [7:0]    m_mem [longint];
  longint unsigned m_mt;
  bit          m_mt_valid = 0;
  logic [31:0] m_hi;
  bit          m_hi_valid = 0;
  bit          m_cv, m_halt, m_init = 0;
  logic [7:0]  m_cd;
  logic [31:0] m_exit;
  logic [2:0]  m_err;
  bit          m_force = 0;
  bit          m_release = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.chk_rd)
          check({e.name, ".rd_data"}, rd_data & e.mask, e.rd & e.mask);
        if (e.chk_state) begin
          check({e.name, ".err"},        {29'h0, err},        {29'h0, e.err});
          check({e.name, ".halt"},       {31'h0, halt},       {31'h0, e.halt});
          check({e.name, ".exit_code"},  exit_code,           e.exit_code);
          check({e.name, ".cons_valid"}, {31'h0, cons_valid}, {31'h0, e.cv});
          check({e.name, ".cons_data"},  {24'h0, cons_data},  {24'h0, e.cd});
        end
      end
    end
  end

  task automatic cycle(input bit r, input bit q, input logic [31:0] a, input logic [1:0] s,
                       input bit w, input logic [31:0] d, input string name);
    exp_t e;
    longint a64;
    bit ram, mmio, rsvd, mis, unm, legal, cv_n;
    int n, off;
    logic [2:0] clr, new_err;
    @(posedge clk); #1;
    if (m_force)   force dut.r_mtime = 64'h0000_0000_FFFF_FFFF;
    if (m_release) release dut.r_mtime;
    rst = r; req = q; addr = a; sz = s; wr = w; wdata = d;

    a64   = longint'(a);
    n     = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    ram   = (a64 >= longint'(DMEM_BASE)) && (a64 < RAM_END);
    mmio  = (a64 >= longint'(MMIO_BASE)) && (a64 < longint'(MMIO_BASE) + 32);
    rsvd  = (s == 2'b10);
    mis   = (s == 2'b01 && a[0]) || (s == 2'b11 && a[1:0] != 2'b00) ||
            (mmio && (s == 2'b00 || s == 2'b01));
    unm   = !ram && !mmio;
    legal = q && !rsvd && !mis && !unm;
    off   = int'(a64 - longint'(MMIO_BASE));

    e.name = name; e.rd = 32'h0; e.mask = 32'hFFFF_FFFF;
    e.chk_rd = m_init && !(q && w);
    e.chk_state = m_init;
    e.err = m_err; e.halt = m_halt; e.exit_code = m_exit; e.cv = m_cv; e.cd = m_cd;
    if (legal && !w) begin
      if (ram) begin
        for (int i = 0; i < n; i++) begin
          if (m_mem.exists(a64 + i)) e.rd |= 32'(m_mem[a64 + i]) << (8 * i);
          else e.mask &= ~(32'hFF << (8 * i));
        end
      end else begin
        case (off)
          0: begin
            if (m_force) e.rd = 32'hFFFF_FFFF;
            else if (m_mt_valid) e.rd = m_mt[31:0];
            else e.mask = 32'h0;
          end
          4:  if (m_hi_valid) e.rd = m_hi; else e.mask = 32'h0;
          8:  e.rd = m_exit;
          16: e.rd = {29'h0, m_err};
          default: e.rd = 32'h0;
        endcase
      end
    end
    exp_q.push_back(e);

    if (r) begin
      m_mt = 0; m_mt_valid = 1; m_hi = 0; m_hi_valid = 1;
      m_cv = 0; m_cd = 0; m_halt = 0; m_exit = 0; m_err = 0; m_init = 1;
    end else begin
      new_err = q ? {rsvd, unm, mis} : 3'b000;
      clr = 3'b000; cv_n = 0;
      if (legal && w) begin
        if (ram) begin
          for (int i = 0; i < n; i++) m_mem[a64 + i] = 8'(d >> (8 * i));
        end else begin
          case (off)
            8:  if (!m_halt) begin m_halt = 1; m_exit = d; end
            12: begin cv_n = 1; m_cd = d[7:0]; end
            16: clr = d[2:0];
            default: ;
          endcase
        end
      end
      if (legal && !w && mmio && off == 0) begin
        if (m_force) begin m_hi = 32'h0; m_hi_valid = 1; end
        else begin m_hi = m_mt[63:32]; m_hi_valid = m_mt_valid; end
      end
      m_err = (m_err & ~clr) | new_err;
      m_cv  = cv_n;
      m_mt  = m_mt + 1;
      if (m_force) m_mt_valid = 0;
    end
  endtask

  task automatic idle(input string name);
    cycle(0, 0, 32'h0, 2'b00, 0, 32'h0, name);
  endtask

  initial begin : driver
    logic [31:0] ra, rdat;
    logic [1:0]  rs;
    int          sel;
    rst = 1; req = 0; addr = 0; sz = 0; wr = 0; wdata = 0;
    cycle(1, 0, 0, 0, 0, 0, "reset0");
    cycle(1, 0, 0, 0, 0, 0, "reset1");
    idle("idle_after_reset");
    cycle(0, 1, MMIO_BASE, 2'b11, 0, 0, "mtime_lo_n");

    cycle(0, 1, 32'h0001_0004, 2'b11, 1, 32'hDEAD_BEEF, "wr_word");
    cycle(0, 1, 32'h0001_0004, 2'b00, 0, 0, "rd_b4");
    cycle(0, 1, 32'h0001_0005, 2'b00, 0, 0, "rd_b5");
    cycle(0, 1, 32'h0001_0006, 2'b00, 0, 0, "rd_b6");
    cycle(0, 1, 32'h0001_0007, 2'b00, 0, 0, "rd_b7");
    cycle(0, 1, 32'h0001_0006, 2'b01, 0, 0, "rd_h6");
    cycle(0, 1, 32'h0001_0005, 2'b00, 1, 32'h0000_0055, "wr_b5");
    cycle(0, 1, 32'h0001_0004, 2'b11, 0, 0, "rd_after_b5");
    cycle(0, 1, 32'h0001_0006, 2'b01, 1, 32'h0000_1234, "wr_h6");
    cycle(0, 1, 32'h0001_0004, 2'b11, 0, 0, "rd_after_h6");

    cycle(0, 1, 32'h0001_0000, 2'b11, 1, 32'hA5A5_A5A5, "wr_w0");
    cycle(0, 1, 32'h0001_0001, 2'b01, 1, 32'h0000_FFFF, "wr_h_misaligned");
    cycle(0, 1, 32'h0001_0000, 2'b11, 0, 0, "rd_w0_unchanged");
    cycle(0, 1, 32'h0000_0000, 2'b11, 0, 0, "rd_unmapped");
    idle("err_011");
    cycle(0, 1, MMIO_BASE + 32'h10, 2'b11, 0, 0, "rd_err_status");
    cycle(0, 1, MMIO_BASE + 32'h10, 2'b11, 1, 32'h3, "clr_err");
    idle("err_cleared");
    cycle(0, 1, 32'h0001_0000, 2'b10, 0, 0, "rd_reserved");
    cycle(0, 1, MMIO_BASE + 32'h8, 2'b00, 0, 0, "rd_mmio_byte");
    cycle(0, 1, MMIO_BASE + 32'h10, 2'b11, 1, 32'h7, "clr_all");

    cycle(0, 1, 32'h0001_0FFC, 2'b11, 1, 32'h1357_9BDF, "wr_last_word");
    cycle(0, 1, 32'h0001_0FFC, 2'b11, 0, 0, "rd_last_word");
    cycle(0, 1, 32'h0001_1000, 2'b11, 0, 0, "rd_past_end");
    cycle(0, 1, 32'h0000_FFFC, 2'b11, 0, 0, "rd_before_base");
    cycle(0, 1, MMIO_BASE + 32'h14, 2'b11, 1, 32'hFFFF_FFFF, "wr_mmio_0x14");
    cycle(0, 1, MMIO_BASE + 32'h14, 2'b11, 0, 0, "rd_mmio_0x14");
    cycle(0, 1, MMIO_BASE, 2'b11, 1, 32'h1234_5678, "wr_mtime_lo_ignored");
    cycle(0, 1, MMIO_BASE, 2'b11, 0, 0, "rd_mtime_lo");
    cycle(0, 1, MMIO_BASE + 32'h4, 2'b11, 0, 0, "rd_mtime_hi");
    cycle(0, 1, MMIO_BASE + 32'h10, 2'b11, 1, 32'h7, "clr_all2");

    cycle(0, 1, MMIO_BASE + 32'hC, 2'b11, 1, 32'h41, "cons_41");
    cycle(0, 1, MMIO_BASE + 32'hC, 2'b11, 1, 32'h42, "cons_42");
    idle("cons_pulse_41");
    idle("cons_pulse_42_seen");
    cycle(0, 1, MMIO_BASE + 32'hC, 2'b11, 0, 0, "rd_console");

    cycle(0, 1, MMIO_BASE + 32'h8, 2'b11, 1, 32'h7, "tohost_7");
    cycle(0, 1, MMIO_BASE + 32'h8, 2'b11, 1, 32'h9, "tohost_9");
    cycle(0, 1, MMIO_BASE + 32'h8, 2'b11, 0, 0, "rd_tohost");
    cycle(0, 1, 32'h0001_0004, 2'b11, 0, 0, "rd_after_halt");

    m_force = 1;
    cycle(0, 1, MMIO_BASE, 2'b11, 0, 0, "mtime_lo_forced");
    m_force = 0; m_release = 1;
    cycle(0, 1, MMIO_BASE + 32'h4, 2'b11, 0, 0, "mtime_hi_snapshot");
    m_release = 0;

    cycle(0, 1, 32'h0001_0008, 2'b11, 1, 32'h1111_1111, "wr_w8");
    cycle(0, 1, 32'h0001_0003, 2'b11, 0, 0, "mis_before_reset");
    cycle(1, 1, 32'h0001_0008, 2'b11, 1, 32'hCAFE_F00D, "reset_mid_run_wr");
    cycle(0, 1, 32'h0001_0008, 2'b11, 0, 0, "rd_w8_after_reset");
    cycle(0, 1, MMIO_BASE, 2'b11, 0, 0, "mtime_after_reset");

    for (int k = 0; k < 800; k++) begin
      sel = int'($urandom_range(0, 99));
      rs  = 2'($urandom_range(0, 3));
      rdat = $urandom;
      if (sel < 65)      ra = DMEM_BASE + 32'($urandom_range(0, 127));
      else if (sel < 88) ra = MMIO_BASE + 32'($urandom_range(0, 31));
      else               ra = $urandom;
      if (sel >= 95) idle("rand_idle");
      else cycle(0, 1, ra, rs, 1'($urandom_range(0, 1)), rdat, "rand");
    end

    idle("final0");
    idle("final1");
    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sparrow_dmem_resp.md
Name: sparrow_dmem_resp

Overview:
- Data-memory responder for the sparrow core: the target end of the core's data memory request interface (req/addr/byte_en/wr/wr_data -> rd_data).
- Contains a word-organised RAM with byte/half/word lane writes and a small MMIO region.
- MMIO holds a 64-bit cycle timer, a console byte port, a tohost/halt register and a sticky error-status register.
- Read data is returned combinationally in the same cycle, because the core is single-cycle. Writes and all state updates commit on the rising clock edge.

Parameters:
- DMEM_BASE, 32'h0001_0000, byte base address of the RAM window.
- DMEM_DEPTH, 1024, RAM depth in 32-bit words (power of two).
- MMIO_BASE, 32'hFFFF_0000, base of the 32-byte MMIO window.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous, active-high reset.
- i_dmem_req  input  1  access request valid this cycle.
- i_dmem_addr  input  32  byte address.
- i_dmem_byte_en  input  2  size: 2'b00 byte, 2'b01 half, 2'b11 word, 2'b10 reserved.
- i_dmem_wr_en  input  1  1 = write, 0 = read.
- i_dmem_wr_data  input  32  write data, right-justified (byte in [7:0], half in [15:0]).
- o_dmem_rd_data  output  32  read data, right-justified and zero-filled above the access size; combinational.
- o_cons_valid  output  1  one-cycle pulse, console byte written.
- o_cons_data  output  8  console byte, valid with o_cons_valid.
- o_halt  output  1  sticky; set by the first write to TOHOST.
- o_exit_code  output  32  data of the first TOHOST write.
- o_err  output  3  sticky error flags: [0] misaligned, [1] unmapped address, [2] reserved size.

Behaviour:
- Reset: one clock, synchronous and active-high.
  - Reset is synchronous: i_reset high at a rising edge clears all registers. Registered outputs take their reset values at that edge.
  - Reset values: mtime = 0, hi_shadow = 0, o_cons_valid = 0, o_cons_data = 0, o_halt = 0, o_exit_code = 0, o_err = 0.
  - RAM contents are not reset. Reset overrides any access issued in the same cycle.
- Idle:
  - i_dmem_req = 0 -> o_dmem_rd_data = 0 and no state change; i_dmem_wr_en is ignored.
- Decode:
  - RAM hit: DMEM_BASE <= addr < DMEM_BASE + 4*DMEM_DEPTH.
  - MMIO hit: addr[31:5] == MMIO_BASE[31:5].
  - Anything else is unmapped.
- Legality:
  - half requires addr[0] = 0; word requires addr[1:0] = 0.
  - Any illegal access (misaligned, unmapped or reserved size) performs no write and reads 0.
  - At the next edge the matching o_err bit is set. Several bits may set in one cycle.
- RAM read:
  - word index = (addr - DMEM_BASE) >> 2.
  - The selected lane (addr[1:0] for byte, addr[1] for half) is shifted to bit 0; upper bits are 0.
- RAM write:
  - Commits at the edge; only the addressed lanes change.
  - A read of the same address in the following cycle returns the new data.
- MMIO map (offset from MMIO_BASE; word accesses only, byte/half to MMIO count as misaligned):
  - 0x00 MTIME_LO, read-only: returns mtime[31:0]. A read also loads hi_shadow <= mtime[63:32] at that edge.
  - 0x04 MTIME_HI, read-only: returns hi_shadow.
  - 0x08 TOHOST: read returns o_exit_code. A write while o_halt = 0 sets o_halt = 1 and o_exit_code = wr_data at the edge. Later writes are ignored.
  - 0x0C CONSOLE: read returns 0. A write drives o_cons_valid = 1 and o_cons_data = wr_data[7:0] for exactly the next cycle. Back-to-back writes give consecutive pulses.
  - 0x10 ERR_STATUS: read returns {29'b0, o_err}. A write clears the bits set in wr_data[2:0] (write-1-to-clear). A new error in the same cycle wins over the clear.
  - Writes to MTIME_LO/MTIME_HI are ignored.
  - Other offsets (0x14-0x1C): reads return 0, writes are ignored; no error flag is raised.
- mtime:
  - 64-bit counter, increments by 1 every cycle out of reset; wraps 2^64-1 -> 0.
  - The value read is the pre-increment value of that cycle.
- o_halt does not block further accesses; RAM and MMIO keep operating.

Test Plan:
- Word write 0xDEADBEEF to 0x0001_0004, then byte reads at 0x0001_0004..7 -> 0xEF, 0xBE, 0xAD, 0xDE zero-extended; half read at 0x0001_0006 -> 0x0000_DEAD.
- Byte write 0x55 to 0x0001_0005 over 0xDEADBEEF -> word read 0xDEAD55EF; half write 0x1234 to 0x0001_0006 -> 0x123455EF.
- Half write at 0x0001_0001 -> RAM unchanged, o_err = 3'b001; word read at 0x0000_0000 -> rd_data 0, o_err = 3'b011; write 0x3 to ERR_STATUS -> o_err = 0 next cycle.
- Release reset, read MTIME_LO at cycle N -> N; force mtime = 0x0000_0000_FFFF_FFFF, read LO -> 0xFFFF_FFFF, then read HI -> 0x0 (snapshot, not 1).
- Write 0x41 then 0x42 to CONSOLE in consecutive cycles -> o_cons_valid high two cycles with o_cons_data 0x41 then 0x42.
- Write 0x7 then 0x9 to TOHOST -> o_halt = 1, o_exit_code = 0x7; assert i_reset mid-run -> all outputs return to their reset values at that edge.
